// File: rtl/dmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_if
//
// Bundles every bus signal of the two-port data-memory arbiter. These are the
// CPU requester (port 0), the loader/debug requester (port 1), the
// single-ported memory and the grant counters.
//
// Handshake: a requester raises reqN with weN/addrN/wdataN. It keeps all four
// stable until it sees gntN=1 in the same cycle. The access is accepted in
// exactly that cycle, and nothing is latched for an ungranted request. For a
// read, rvalidN/rdataN are presented exactly one cycle after the grant, with
// no back-pressure. The memory port follows the same rule: mem_en is a
// one-cycle strobe, and mem_rdata is expected one cycle after a read strobe.
//
// Modports
//   slave  : the arbiter itself (consumes requests and mem_rdata)
//   master : the environment (requesters plus memory model)
// ---------------------------------------------------------------------------
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int CW = 16
);
  // port 0 (CPU)
  logic          req0;
  logic          we0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          gnt0;
  logic          rvalid0;
  logic [DW-1:0] rdata0;
  logic          stall;

  // port 1 (loader / debug)
  logic          req1;
  logic          we1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          gnt1;
  logic          rvalid1;
  logic [DW-1:0] rdata1;

  // memory port
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // grant counters
  logic [CW-1:0] gcnt0;
  logic [CW-1:0] gcnt1;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  mem_rdata,
    output gnt0, rvalid0, rdata0, stall,
    output gnt1, rvalid1, rdata1,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output gcnt0, gcnt1
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output mem_rdata,
    input  gnt0, rvalid0, rdata0, stall,
    input  gnt1, rvalid1, rdata1,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  gcnt0, gcnt1
  );
endinterface

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Two-requester arbiter in front of a single-ported data memory with a
// one-cycle read latency. It issues at most one access per cycle. On
// contention, a round-robin pointer alternates the winner, so neither port
// waits more than one cycle. Read data is routed back to whichever port
// issued the read, one cycle after its grant. Reads can issue every cycle.
//
// Ports
//   clk        : single clock, rising edge
//   reset      : synchronous, active-low
//   bus        : dmem_arbiter_if.slave
//                (requesters, memory port, grant counters)
//   dbg_ptr_o  : current round-robin pointer (0 = CPU wins a tie)
// ---------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic            clk,
  input  logic            reset,
  dmem_arbiter_if.slave   bus,
  output logic            dbg_ptr_o
);

  typedef enum logic {
    PTR_P0 = 1'b0,
    PTR_P1 = 1'b1
  } ptr_e;

  localparam logic [CW-1:0] GCNT_MAX = '1;

  ptr_e          ptr_q, ptr_d;
  logic          rd_pend_q, rd_pend_d;
  logic          rd_id_q, rd_id_d;
  logic [CW-1:0] gcnt0_q, gcnt0_d;
  logic [CW-1:0] gcnt1_q, gcnt1_d;

  // High from any edge that sampled reset low until the first edge that
  // samples it high again. It blanks every output for that whole window.
  // Outputs therefore change only at clock edges, never mid-cycle, and a
  // read granted just before reset is never answered.
  logic          rst_hold_q;

  logic          sel0, sel1;

  // ---------------------------------------------------------------------
  // Grant selection
  // ---------------------------------------------------------------------
  always_comb begin
    sel0 = 1'b0;
    sel1 = 1'b0;
    if (!rst_hold_q) begin
      if (bus.req0 && (!bus.req1 || ptr_q == PTR_P0)) begin
        sel0 = 1'b1;
      end else if (bus.req1) begin
        sel1 = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    ptr_d     = ptr_q;
    rd_pend_d = 1'b0;
    rd_id_d   = rd_id_q;
    gcnt0_d   = gcnt0_q;
    gcnt1_d   = gcnt1_q;

    // Pointer always points away from the last winner.
    if (sel0) begin
      ptr_d = PTR_P1;
    end else if (sel1) begin
      ptr_d = PTR_P0;
    end

    // Tag a granted read so its data can be routed next cycle. A new read
    // simply overwrites the tag; the previous one is being returned now.
    if (sel0 && !bus.we0) begin
      rd_pend_d = 1'b1;
      rd_id_d   = 1'b0;
    end else if (sel1 && !bus.we1) begin
      rd_pend_d = 1'b1;
      rd_id_d   = 1'b1;
    end

    // Saturating grant counters.
    if (sel0 && gcnt0_q != GCNT_MAX) begin
      gcnt0_d = gcnt0_q + 1'b1;
    end
    if (sel1 && gcnt1_q != GCNT_MAX) begin
      gcnt1_d = gcnt1_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      rst_hold_q <= 1'b1;
      ptr_q      <= PTR_P0;
      rd_pend_q  <= 1'b0;
      rd_id_q    <= 1'b0;
      gcnt0_q    <= '0;
      gcnt1_q    <= '0;
    end else begin
      rst_hold_q <= 1'b0;
      ptr_q      <= ptr_d;
      rd_pend_q  <= rd_pend_d;
      rd_id_q    <= rd_id_d;
      gcnt0_q    <= gcnt0_d;
      gcnt1_q    <= gcnt1_d;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  logic rv0, rv1;

  always_comb begin
    rv0 = !rst_hold_q && rd_pend_q && !rd_id_q;
    rv1 = !rst_hold_q && rd_pend_q &&  rd_id_q;

    bus.gnt0    = sel0;
    bus.gnt1    = sel1;
    bus.stall   = !rst_hold_q && bus.req0 && !sel0;

    bus.rvalid0 = rv0;
    bus.rvalid1 = rv1;
    bus.rdata0  = rv0 ? bus.mem_rdata : '0;
    bus.rdata1  = rv1 ? bus.mem_rdata : '0;

    // Memory mux: idle fields are forced to zero, not left floating.
    bus.mem_en    = sel0 || sel1;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (sel0) begin
      bus.mem_we    = bus.we0;
      bus.mem_addr  = bus.addr0;
      bus.mem_wdata = bus.wdata0;
    end else if (sel1) begin
      bus.mem_we    = bus.we1;
      bus.mem_addr  = bus.addr1;
      bus.mem_wdata = bus.wdata1;
    end

    bus.gcnt0 = rst_hold_q ? '0 : gcnt0_q;
    bus.gcnt1 = rst_hold_q ? '0 : gcnt1_q;
  end

  assign dbg_ptr_o = ptr_q;

endmodule
